// File: rtl/cam_vga_pkg.sv
// Shared VGA timing constants, capture FSM states and the luma helper for the camera-to-VGA path.
package cam_vga_pkg;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FP         = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BP         = 48;
    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FP         = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BP         = 33;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_FRAME_PIXELS = 307200;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_WAIT_VS = 2'd1,
        CAP_CAPTURE = 2'd2
    } cap_state_t;

    // Shift-and-add luma on nibble-expanded RGB; only the top nibble is kept in the frame buffer.
    function automatic logic [3:0] luma_nibble(input logic [3:0] r, input logic [3:0] g,
                                               input logic [3:0] b);
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        logic [7:0] y;
        r8 = {r, 4'h0};
        g8 = {g, 4'h0};
        b8 = {b, 4'h0};
        y  = (r8 >> 2) + (r8 >> 5) + (g8 >> 1) + (g8 >> 4) + (b8 >> 4) + (b8 >> 5);
        return 4'(y >> 4);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster generator: h/v counters advanced on the pixel enable, syncs, active flag, read address.
module vga_timing
    import cam_vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int ADDR_W   = $clog2(VGA_FRAME_PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int H_TOTAL  = H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL  = V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int HS_START = H_ACTIVE + VGA_H_FP;
    localparam int HS_END   = HS_START + VGA_H_SYNC;
    localparam int VS_START = V_ACTIVE + VGA_V_FP;
    localparam int VS_END   = VS_START + VGA_V_SYNC;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] line_base;

    // line_base tracks v*H_ACTIVE so the read address needs no multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
        end else if (pix_en) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                if (v_cnt == VW'(V_TOTAL - 1)) begin
                    v_cnt     <= '0;
                    line_base <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (v_cnt < VW'(V_ACTIVE - 1))
                        line_base <= line_base + ADDR_W'(H_ACTIVE);
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hsync   = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
    assign vsync   = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
    assign rd_addr = line_base + ADDR_W'(h_cnt);

endmodule

// File: rtl/cam_vga_top.sv
// OV7670 RGB444 capture -> 4-bit luma frame buffer -> VGA scan-out, all on i_top_clk.
// state       | meaning
// CAP_IDLE    | camera not started, no capture
// CAP_WAIT_VS | camera ready, waiting for the first frame start (vsync fall)
// CAP_CAPTURE | assembling pixels; vsync high rewinds to address 0
module cam_vga_top
    import cam_vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DEPTH = 2
) (
    input  logic       i_top_clk,
    input  logic       i_top_rstn,
    input  logic       i_top_cam_start,
    output logic       o_top_cam_done,
    input  logic       i_top_pclk,
    input  logic [7:0] i_top_pix_byte,
    input  logic       i_top_pix_vsync,
    input  logic       i_top_pix_href,
    output logic       o_top_reset,
    output logic       o_top_pwdn,
    output logic       o_top_xclk,
    output logic       o_top_siod,
    output logic       o_top_sioc,
    output logic [3:0] o_top_vga_red,
    output logic [3:0] o_top_vga_green,
    output logic [3:0] o_top_vga_blue,
    output logic       o_top_vga_hsync,
    output logic       o_top_vga_vsync
);

    localparam int FRAME  = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W = $clog2(FRAME);
    localparam int DIV_W  = $clog2(CLK_DIV);

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic              pix_en;
    logic              xclk_q;
    logic              cam_rst_q;
    logic              cam_done_q;
    logic [10:0]       sync_q [SYNC_DEPTH];
    logic              s_pclk;
    logic              s_vsync;
    logic              s_href;
    logic [7:0]        s_byte;
    logic              pclk_d;
    logic              vsync_d;
    logic              pclk_rise;
    logic              vs_fall;
    cap_state_t        state;
    logic              phase;
    logic [3:0]        r_nib;
    logic              pix_valid;
    logic [3:0]        pix_r;
    logic [3:0]        pix_g;
    logic [3:0]        pix_b;
    logic              y_valid;
    logic [3:0]        y_nib;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_data;
    logic [3:0]        frame_mem [FRAME];
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_active;
    logic              hs_d;
    logic              vs_d;
    logic              act_d;

    always_comb begin
        div_nxt = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end
    assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge i_top_clk or negedge i_top_rstn) begin
        if (!i_top_rstn) begin
            div_cnt    <= '0;
            xclk_q     <= 1'b0;
            cam_rst_q  <= 1'b0;
            cam_done_q <= 1'b0;
            pclk_d     <= 1'b0;
            vsync_d    <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            xclk_q    <= (div_nxt >= DIV_W'(CLK_DIV / 2));
            cam_rst_q <= 1'b1;
            if (i_top_cam_start)
                cam_done_q <= 1'b1;
            pclk_d    <= s_pclk;
            vsync_d   <= s_vsync;
        end
    end

    // pclk travels through the same chain as the data so sampled edges and bytes stay aligned.
    always_ff @(posedge i_top_clk or negedge i_top_rstn) begin
        if (!i_top_rstn) begin
            for (int i = 0; i < SYNC_DEPTH; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {i_top_pclk, i_top_pix_vsync, i_top_pix_href, i_top_pix_byte};
            for (int i = 1; i < SYNC_DEPTH; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign {s_pclk, s_vsync, s_href, s_byte} = sync_q[SYNC_DEPTH-1];
    assign pclk_rise = s_pclk & ~pclk_d;
    assign vs_fall   = vsync_d & ~s_vsync;

    always_ff @(posedge i_top_clk or negedge i_top_rstn) begin
        if (!i_top_rstn) begin
            state     <= CAP_IDLE;
            phase     <= 1'b0;
            r_nib     <= '0;
            pix_valid <= 1'b0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
            wr_addr   <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (y_valid)
                wr_addr <= (wr_addr == ADDR_W'(FRAME - 1)) ? '0 : wr_addr + 1'b1;
            case (state)
                CAP_IDLE: begin
                    if (cam_done_q)
                        state <= CAP_WAIT_VS;
                end
                CAP_WAIT_VS: begin
                    phase <= 1'b0;
                    if (vs_fall)
                        state <= CAP_CAPTURE;
                end
                CAP_CAPTURE: begin
                    if (s_vsync) begin
                        wr_addr <= '0;
                        phase   <= 1'b0;
                    end else if (!s_href) begin
                        phase <= 1'b0;
                    end else if (pclk_rise) begin
                        if (!phase) begin
                            r_nib <= s_byte[3:0];
                            phase <= 1'b1;
                        end else begin
                            pix_r     <= r_nib;
                            pix_g     <= s_byte[7:4];
                            pix_b     <= s_byte[3:0];
                            pix_valid <= 1'b1;
                            phase     <= 1'b0;
                        end
                    end
                end
                default: state <= CAP_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_top_clk or negedge i_top_rstn) begin
        if (!i_top_rstn) begin
            y_valid <= 1'b0;
            y_nib   <= '0;
        end else begin
            y_valid <= pix_valid;
            if (pix_valid)
                y_nib <= luma_nibble(pix_r, pix_g, pix_b);
        end
    end

    // Nonblocking write and read give read-old-data on a same-address collision.
    always_ff @(posedge i_top_clk) begin
        if (y_valid)
            frame_mem[wr_addr] <= y_nib;
        if (pix_en && vga_active)
            rd_data <= frame_mem[rd_addr];
    end

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_vga_timing (
        .clk     (i_top_clk),
        .rst_n   (i_top_rstn),
        .pix_en  (pix_en),
        .hsync   (vga_hs),
        .vsync   (vga_vs),
        .active  (vga_active),
        .rd_addr (rd_addr)
    );

    always_ff @(posedge i_top_clk or negedge i_top_rstn) begin
        if (!i_top_rstn) begin
            hs_d  <= 1'b1;
            vs_d  <= 1'b1;
            act_d <= 1'b0;
        end else if (pix_en) begin
            hs_d  <= vga_hs;
            vs_d  <= vga_vs;
            act_d <= vga_active;
        end
    end

    assign o_top_vga_red   = act_d ? rd_data : 4'h0;
    assign o_top_vga_green = act_d ? rd_data : 4'h0;
    assign o_top_vga_blue  = act_d ? rd_data : 4'h0;
    assign o_top_vga_hsync = hs_d;
    assign o_top_vga_vsync = vs_d;
    assign o_top_cam_done  = cam_done_q;
    assign o_top_reset     = cam_rst_q;
    assign o_top_pwdn      = 1'b0;
    assign o_top_xclk      = xclk_q;
    assign o_top_siod      = 1'b1;
    assign o_top_sioc      = 1'b1;

endmodule

// File: tb/tb_cam_vga_top.sv
// Directed bench: a reduced-raster instance (32x4) for capture and full-frame VGA checks,
// plus a full 640x480 instance for line timing and reset values.
module tb_cam_vga_top;

    localparam int SH  = 32;
    localparam int SV  = 4;
    localparam int SHT = SH + 160;
    localparam int SVT = SV + 45;
    localparam int SFR = SH * SV;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cam_start = 1'b0;
    logic       pclk = 1'b0;
    logic       href = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] pbyte = 8'h00;

    logic       done, cam_rst, pwdn, xclk, siod, sioc, hs, vs;
    logic [3:0] red, green, blue;
    logic       f_done, f_rst, f_pwdn, f_xclk, f_siod, f_sioc, f_hs, f_vs;
    logic [3:0] f_red, f_green, f_blue;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [3:0] y;
    } vec_t;

    vec_t       vecs [10];
    logic [3:0] model_mem [SFR];

    cam_vga_top #(.H_ACTIVE(SH), .V_ACTIVE(SV), .CLK_DIV(4), .SYNC_DEPTH(2)) dut (
        .i_top_clk(clk), .i_top_rstn(rstn), .i_top_cam_start(cam_start), .o_top_cam_done(done),
        .i_top_pclk(pclk), .i_top_pix_byte(pbyte), .i_top_pix_vsync(vsync),
        .i_top_pix_href(href), .o_top_reset(cam_rst), .o_top_pwdn(pwdn), .o_top_xclk(xclk),
        .o_top_siod(siod), .o_top_sioc(sioc), .o_top_vga_red(red), .o_top_vga_green(green),
        .o_top_vga_blue(blue), .o_top_vga_hsync(hs), .o_top_vga_vsync(vs)
    );

    cam_vga_top dut_full (
        .i_top_clk(clk), .i_top_rstn(rstn), .i_top_cam_start(cam_start), .o_top_cam_done(f_done),
        .i_top_pclk(pclk), .i_top_pix_byte(pbyte), .i_top_pix_vsync(vsync),
        .i_top_pix_href(href), .o_top_reset(f_rst), .o_top_pwdn(f_pwdn), .o_top_xclk(f_xclk),
        .o_top_siod(f_siod), .o_top_sioc(f_sioc), .o_top_vga_red(f_red),
        .o_top_vga_green(f_green), .o_top_vga_blue(f_blue), .o_top_vga_hsync(f_hs),
        .o_top_vga_vsync(f_vs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        pbyte = b;
        pclk  = 1'b0;
        clk_n(3);
        pclk  = 1'b1;
        clk_n(3);
    endtask

    task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        clk_n(6);
        vsync = 1'b0;
        clk_n(6);
    endtask

    function automatic logic [3:0] exp_luma(input logic [3:0] r, input logic [3:0] g,
                                            input logic [3:0] b);
        int ri, gi, bi, y;
        ri = int'(r) * 16;
        gi = int'(g) * 16;
        bi = int'(b) * 16;
        y  = ri / 4 + ri / 32 + gi / 2 + gi / 16 + bi / 16 + bi / 32;
        return 4'(y / 16);
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] b0, b1;
        logic [3:0] m;
        logic [13:0] exp_px;
        int p, hp, vp, highs;

        vecs[0] = '{8'hF5, 8'hA3, 4'h7};
        vecs[1] = '{8'hFF, 8'hFF, 4'hE};
        vecs[2] = '{8'h00, 8'h00, 4'h0};
        vecs[3] = '{8'h0F, 8'hF0, 4'hC};
        vecs[4] = '{8'h13, 8'h00, 4'h0};
        vecs[5] = '{8'h08, 8'h00, 4'h2};
        vecs[6] = '{8'h00, 8'h80, 4'h4};
        vecs[7] = '{8'h00, 8'h0F, 4'h1};
        vecs[8] = '{8'h0A, 8'h5C, 4'h6};
        vecs[9] = '{8'hB7, 8'h29, 4'h3};

        // reset values
        clk_n(3);
        #1;
        chk("rst_outputs", {red, green, blue, hs, vs, cam_rst, done, xclk, pwdn, siod, sioc},
            {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("cam_reset_before_edge", cam_rst, 1'b0);
        clk_n(1);
        chk("cam_reset_after_edge", cam_rst, 1'b1);

        // xclk: 4-cycle period, 2 high
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            chk("xclk_phase", xclk, 32'((cyc % 4) >= 2));
            highs += int'(xclk);
            clk_n(1);
        end
        chk("xclk_duty", highs, 4);

        // start handshake
        chk("done_before_start", done, 1'b0);
        cam_start = 1'b1;
        clk_n(1);
        cam_start = 1'b0;
        chk("done_after_start", done, 1'b1);
        clk_n(20);
        chk("done_sticky", done, 1'b1);

        // capture table
        vsync_pulse();
        href = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_pixel(vecs[i].b0, vecs[i].b1);
            clk_n(6);
            chk($sformatf("luma_vec%0d", i), dut.frame_mem[i], vecs[i].y);
            model_mem[i] = vecs[i].y;
        end

        // lone byte then href drop: no write, new line restarts at phase 0
        href = 1'b0;
        send_byte(8'h55);
        href = 1'b1;
        send_byte(8'h0F);
        href = 1'b0;
        send_byte(8'h77);
        clk_n(3);
        href = 1'b1;
        send_pixel(8'h03, 8'h30);
        clk_n(6);
        chk("phase_restart_addr10", dut.frame_mem[10], 4'h2);
        model_mem[10] = 4'h2;

        // vsync mid-frame rewinds to address 0
        href = 1'b0;
        vsync_pulse();
        href = 1'b1;
        send_pixel(8'hFF, 8'hFF);
        clk_n(6);
        chk("vsync_rewind_addr0", dut.frame_mem[0], 4'hE);
        model_mem[0] = 4'hE;

        // fill the rest of the frame with random pixels, then one more wraps to 0
        for (int i = 1; i < SFR; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            send_pixel(b0, b1);
            model_mem[i] = exp_luma(b0[3:0], b1[7:4], b1[3:0]);
        end
        send_pixel(8'h0A, 8'h5C);
        clk_n(6);
        href = 1'b0;
        chk("wrap_addr0", dut.frame_mem[0], 4'h6);
        model_mem[0] = 4'h6;
        chk("last_addr", dut.frame_mem[SFR-1], model_mem[SFR-1]);
        chk("addr1", dut.frame_mem[1], model_mem[1]);

        // one full reduced frame of scan-out, one comparison per pixel slot
        while ((cyc % 4) != 0) clk_n(1);
        for (int s = 0; s < SHT * SVT; s++) begin
            p  = cyc / 4 - 1;
            hp = p % SHT;
            vp = (p / SHT) % SVT;
            m  = (hp < SH && vp < SV) ? model_mem[vp * SH + hp] : 4'h0;
            exp_px = {m, m, m, !(hp >= SH + 16 && hp < SH + 112), !(vp >= SV + 10 && vp < SV + 12)};
            chk($sformatf("vga_px h=%0d v=%0d", hp, vp), {red, green, blue, hs, vs}, exp_px);
            clk_n(4);
        end

        // full-size raster: one line of sync timing
        for (int s = 0; s < 800; s++) begin
            p  = cyc / 4 - 1;
            hp = p % 800;
            vp = (p / 800) % 525;
            chk($sformatf("full_sync h=%0d v=%0d", hp, vp), {f_hs, f_vs},
                {!(hp >= 656 && hp < 752), !(vp >= 490 && vp < 492)});
            clk_n(4);
        end

        // mid-frame asynchronous reset
        clk_n(2);
        rstn = 1'b0;
        #1;
        chk("midrst_small", {red, green, blue, hs, vs, cam_rst, done, xclk},
            {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("midrst_full", {f_red, f_green, f_blue, f_hs, f_vs, f_rst, f_done, f_xclk,
                            f_pwdn, f_siod, f_sioc},
            {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        clk_n(2);
        rstn = 1'b1;
        clk_n(3);
        chk("done_cleared_by_reset", done, 1'b0);
        chk("cam_reset_released", cam_rst, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
